// File: rtl/siso_frame_deserializer_if.sv
// Bundle of serial input, parallel output and error pulses for the frame deserializer.
// Latency: n/a (wires only). Backpressure: data_ready from consumer qualifies data_valid.
// Ports: serial_in, data_ready (towards deserializer); data_out, data_valid, frame_err, overrun (from it).
interface siso_frame_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             serial_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             frame_err;
    logic             overrun;

    // master: the environment driving bits in and consuming words
    modport master (
        output serial_in,
        output data_ready,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  overrun
    );

    // slave: the deserializer itself
    modport slave (
        input  serial_in,
        input  data_ready,
        output data_out,
        output data_valid,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/siso_frame_deserializer.sv
// Purpose: frames start(1) + WIDTH data bits LSB-first [+ even parity] + stop(0) into a word.
// Latency: word valid the cycle after the stop bit edge; frame_err/overrun are 1-cycle pulses.
// Backpressure: one-word holding buffer; a good frame arriving while it is full and not
//   being consumed is dropped and flagged with overrun.
// Ports: clk, reset (async, active-high), bus (slave modport of siso_frame_deserializer_if).
// Optional macro FRAME_DESER_PARITY_EN adds an even-parity bit between data and stop.
module siso_frame_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    siso_frame_deserializer_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef FRAME_DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             ferr_q;
    logic             ovr_q;
    logic             good;
    logic             bad;
    logic             parity_ok;

`ifdef FRAME_DESER_PARITY_EN
    logic par_bit, par_nxt;
    // even parity: data bits plus parity bit must hold an even number of ones
    assign parity_ok = ~(^{shreg, par_bit});
`else
    assign parity_ok = 1'b1;
`endif

    // next-state and frame decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        good      = 1'b0;
        bad       = 1'b0;
`ifdef FRAME_DESER_PARITY_EN
        par_nxt   = par_bit;
`endif
        case (state)
            IDLE: begin
                if (bus.serial_in) begin
                    state_nxt = DATA;
                    cnt_nxt   = '0;
                end
            end
            DATA: begin
                shreg_nxt[cnt] = bus.serial_in;
                if (cnt == CW'(WIDTH - 1)) begin
                    cnt_nxt = '0;
`ifdef FRAME_DESER_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
`ifdef FRAME_DESER_PARITY_EN
            PARITY: begin
                par_nxt   = bus.serial_in;
                state_nxt = STOP;
            end
`endif
            STOP: begin
                // always back to IDLE: a 1 here is a bad stop, never a new start
                state_nxt = IDLE;
                if (!bus.serial_in && parity_ok) begin
                    good = 1'b1;
                end else begin
                    bad = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef FRAME_DESER_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            shreg  <= shreg_nxt;
            ferr_q <= bad;
            ovr_q  <= 1'b0;
`ifdef FRAME_DESER_PARITY_EN
            par_bit <= par_nxt;
`endif
            if (good) begin
                // buffer free, or being consumed this edge: load; otherwise drop
                if (!valid_q || bus.data_ready) begin
                    data_q  <= shreg;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && bus.data_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;

endmodule
